// File: rtl/adc_sram_writer.sv
// ---------------------------------------------------------------------------
// adc_sram_writer
//
// Downstream stage of the LVDS ADC front end. Captured samples arrive as data
// plus active-low cs/oe/we strobes, are queued in a small FIFO and written to
// an external asynchronous SRAM used as a circular sample buffer. A single-word
// host readback port shares the SRAM; writes always win arbitration.
//
// Build option: define SRAM_PARITY_EN to store an even-parity bit above each
// sample (SRAM word = {^data, data}) and check it on readback. Without it the
// SRAM word is just the sample and rd_parity_err stays 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_data, in_*_n     sample and active-low strobes from the ADC stage
//   enable              1 = accept samples
//   clr_status          pulse, clears overflow / wrapped
//   rd_req, rd_addr     readback request pulse and address
//   rd_busy, rd_valid   readback pending / 1-cycle data-valid pulse
//   rd_data             readback data, held until the next read completes
//   rd_parity_err       parity mismatch, qualified by rd_valid
//   wr_ptr              next SRAM write address
//   fifo_level          FIFO occupancy
//   overflow, wrapped   sticky status flags
//   sram_*              SRAM address, data bus halves and active-low strobes
// ---------------------------------------------------------------------------
module adc_sram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_WAIT    = 2,
    parameter int RD_WAIT    = 2,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
`ifdef SRAM_PARITY_EN
    localparam int SW = DATA_WIDTH + 1
`else
    localparam int SW = DATA_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_cs_n,
    input  logic                  in_oe_n,
    input  logic                  in_we_n,
    input  logic                  enable,
    input  logic                  clr_status,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_parity_err,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [SW-1:0]         sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [SW-1:0]         sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int MAXW = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD,
        ST_RD_SETUP, ST_RD_WAIT, ST_RD_DONE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           wait_cnt;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;

    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           head_idx;
    logic [PW-1:0]           tail_idx;
    logic                    sample_valid;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    drop;

    function automatic logic [SW-1:0] sram_word(input logic [DATA_WIDTH-1:0] d);
`ifdef SRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign sample_valid = !in_cs_n && !in_oe_n && in_we_n && enable;
    assign fifo_full    = (fifo_level == LW'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_level == '0);
    // The head entry leaves the FIFO in the write hold cycle, so a full FIFO
    // can still take a sample arriving in that same cycle.
    assign pop          = (state == ST_WR_HOLD);
    assign push         = sample_valid && (!fifo_full || pop);
    assign drop         = sample_valid && fifo_full && !pop;

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail_idx] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_idx   <= '0;
            tail_idx   <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                tail_idx <= tail_idx + PW'(1);
            if (pop)
                head_idx <= head_idx + PW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // SRAM sequencer. Strobes are registered, so each transition loads the
    // strobe values of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            wr_ptr        <= '0;
            overflow      <= 1'b0;
            wrapped       <= 1'b0;
            rd_busy       <= 1'b0;
            rd_addr_q     <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            rd_parity_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            if (rd_req && !rd_busy) begin
                rd_busy   <= 1'b1;
                rd_addr_q <= rd_addr;
            end

            // Sets below are placed after the clear so a coincident event wins.
            if (clr_status) begin
                overflow <= 1'b0;
                wrapped  <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state       <= ST_WR_SETUP;
                        sram_addr   <= wr_ptr;
                        sram_dq_out <= sram_word(fifo_mem[head_idx]);
                        sram_dq_oe  <= 1'b1;
                        sram_ce_n   <= 1'b0;
                    end else if (rd_busy) begin
                        state     <= ST_RD_SETUP;
                        sram_addr <= rd_addr_q;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end
                end
                ST_WR_SETUP: begin
                    state     <= ST_WR_PULSE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= CW'(WR_WAIT - 1);
                end
                ST_WR_PULSE: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                ST_WR_HOLD: begin
                    state      <= ST_IDLE;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                    if (&wr_ptr)
                        wrapped <= 1'b1;
                end
                ST_RD_SETUP: begin
                    state    <= ST_RD_WAIT;
                    wait_cnt <= CW'(RD_WAIT - 1);
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_RD_DONE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        rd_valid  <= 1'b1;
                        rd_data   <= sram_dq_in[DATA_WIDTH-1:0];
`ifdef SRAM_PARITY_EN
                        rd_parity_err <= (sram_dq_in[SW-1] != ^sram_dq_in[DATA_WIDTH-1:0]);
`else
                        rd_parity_err <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                ST_RD_DONE: begin
                    state   <= ST_IDLE;
                    rd_busy <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    sram_ce_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
